// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared types and helpers for the convolution address sequencer.
//             Holds the sequencer state encoding and the address/counter
//             width helper used by the interface, top and counters.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package conv_pkg;

   // Sequencer states, explicitly encoded on two bits.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_WAIT_OUT = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // Bits needed to hold any value in 0..span-1; never less than one bit so
   // that degenerate dimensions (e.g. a single channel) still get a port.
   function automatic int unsigned addr_width(input int unsigned span);
      return (span <= 32'd1) ? 32'd1 : 32'($clog2(span));
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_sequencer_if
//  Purpose  : Control, tap-address and output-handshake bundle of the
//             convolution sequencer. Address widths are derived from the
//             same geometry parameters as the sequencer itself.
//  Ports    : master - sequencer side (drives status, taps, output address)
//             slave  - controller/consumer side (drives start, abort,
//                      out_ready)
//  Revision : 1.0  initial release
// ============================================================================
interface conv_sequencer_if
   import conv_pkg::*;
#(
   parameter int INPUT_WIDTH    = 64,
   parameter int INPUT_HEIGHT   = 64,
   parameter int INPUT_CHANNELS = 1,
   parameter int WINDOW_SIZE    = 3,
   parameter int NUM_NEURONS    = 30
) ();

   localparam int unsigned c_ow     = INPUT_WIDTH  - WINDOW_SIZE + 1;
   localparam int unsigned c_oh     = INPUT_HEIGHT - WINDOW_SIZE + 1;
   localparam int unsigned c_in_aw  = addr_width(INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS);
   localparam int unsigned c_w_aw   = addr_width(INPUT_CHANNELS * WINDOW_SIZE * WINDOW_SIZE * NUM_NEURONS);
   localparam int unsigned c_out_aw = addr_width(c_ow * c_oh * NUM_NEURONS);

   logic                start;
   logic                abort;
   logic                out_ready;
   logic                busy;
   logic                done;
   logic                tap_valid;
   logic                tap_first;
   logic                tap_last;
   logic [c_in_aw-1:0]  in_addr;
   logic [c_w_aw-1:0]   w_addr;
   logic                out_valid;
   logic [c_out_aw-1:0] out_addr;

   modport master (
      input  start, abort, out_ready,
      output busy, done, tap_valid, tap_first, tap_last,
             in_addr, w_addr, out_valid, out_addr
   );

   modport slave (
      output start, abort, out_ready,
      input  busy, done, tap_valid, tap_first, tap_last,
             in_addr, w_addr, out_valid, out_addr
   );

endinterface
`default_nettype wire

// File: rtl/conv_index_counter.sv
`default_nettype none
// ============================================================================
//  Module   : conv_index_counter
//  Purpose  : One loop index of the convolution nest. Counts 0..MAX_VAL,
//             wrapping to zero, and flags a carry into the next-outer index.
//  Ports    : clk     - clock
//             rst     - synchronous active-high reset
//             i_clr   - synchronous clear (wins over i_inc)
//             i_inc   - advance by one this cycle
//             o_count - current index value
//             o_carry - i_inc while at MAX_VAL (index wraps this cycle)
//  Revision : 1.0  initial release
// ============================================================================
module conv_index_counter #(
   parameter int MAX_VAL = 1,
   parameter int CNT_W   = 1
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              i_clr,
   input  wire              i_inc,
   output logic [CNT_W-1:0] o_count,
   output logic             o_carry
);

   localparam logic [CNT_W-1:0] c_max_val = CNT_W'(MAX_VAL);
   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

   logic [CNT_W-1:0] r_count;
   logic             w_at_max;

   assign w_at_max = (r_count == c_max_val);

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= w_at_max ? '0 : (r_count + c_one);
      end
   end

   assign o_count = r_count;
   assign o_carry = i_inc && w_at_max;

endmodule
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_sequencer
//  Purpose  : Walks the six-deep convolution loop nest i, j, n, k, l, m
//             (outer to inner). Issues one input/weight tap address pair per
//             cycle while in RUN, then presents the output address in
//             WAIT_OUT until the consumer accepts it.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous active-high reset
//             bus   - conv_sequencer_if.master: start/abort/out_ready in,
//                     busy/done/tap_valid/tap_first/tap_last/in_addr/
//                     w_addr/out_valid/out_addr out
//  Revision : 1.0  initial release
// ============================================================================
module conv_sequencer
   import conv_pkg::*;
#(
   parameter int INPUT_WIDTH    = 64,
   parameter int INPUT_HEIGHT   = 64,
   parameter int INPUT_CHANNELS = 1,
   parameter int WINDOW_SIZE    = 3,
   parameter int NUM_NEURONS    = 30
) (
   input  wire               clk,
   input  wire               reset,
   conv_sequencer_if.master  bus
);

   localparam int unsigned c_ow     = INPUT_WIDTH  - WINDOW_SIZE + 1;
   localparam int unsigned c_oh     = INPUT_HEIGHT - WINDOW_SIZE + 1;
   localparam int unsigned c_in_aw  = addr_width(INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS);
   localparam int unsigned c_w_aw   = addr_width(INPUT_CHANNELS * WINDOW_SIZE * WINDOW_SIZE * NUM_NEURONS);
   localparam int unsigned c_out_aw = addr_width(c_ow * c_oh * NUM_NEURONS);

   localparam int unsigned c_i_w  = addr_width(c_ow);
   localparam int unsigned c_j_w  = addr_width(c_oh);
   localparam int unsigned c_n_w  = addr_width(NUM_NEURONS);
   localparam int unsigned c_k_w  = addr_width(INPUT_CHANNELS);
   localparam int unsigned c_ws_w = addr_width(WINDOW_SIZE);

   localparam logic [c_k_w-1:0]  c_k_max  = c_k_w'(INPUT_CHANNELS - 1);
   localparam logic [c_ws_w-1:0] c_ws_max = c_ws_w'(WINDOW_SIZE - 1);

   state_t r_state;
   state_t w_next_state;

   logic w_run;
   logic w_wait;
   logic w_abort_act;
   logic w_clr;
   logic w_handshake;

   logic [c_i_w-1:0]  w_i_cnt;
   logic [c_j_w-1:0]  w_j_cnt;
   logic [c_n_w-1:0]  w_n_cnt;
   logic [c_k_w-1:0]  w_k_cnt;
   logic [c_ws_w-1:0] w_l_cnt;
   logic [c_ws_w-1:0] w_m_cnt;

   logic w_i_carry;
   logic w_j_carry;
   logic w_n_carry;
   logic w_k_carry;
   logic w_l_carry;
   logic w_m_carry;

   // ------------------------------------------------------------------------
   // Counter control
   // ------------------------------------------------------------------------
   assign w_run       = (r_state == ST_RUN);
   assign w_wait      = (r_state == ST_WAIT_OUT);
   assign w_abort_act = bus.abort && (w_run || w_wait);
   assign w_handshake = w_wait && bus.out_ready;

   // Indices are held at zero whenever no pass is active, so every start
   // begins at the origin regardless of how the previous pass ended.
   assign w_clr = w_abort_act || (r_state == ST_IDLE) || (r_state == ST_DONE);

   // Tap indices (m innermost) advance every RUN cycle; output indices
   // (n innermost) advance only on an accepted output.
   conv_index_counter #(.MAX_VAL(WINDOW_SIZE - 1), .CNT_W(c_ws_w)) u_cnt_m (
      .clk(clk), .rst(reset), .i_clr(w_clr), .i_inc(w_run),
      .o_count(w_m_cnt), .o_carry(w_m_carry)
   );

   conv_index_counter #(.MAX_VAL(WINDOW_SIZE - 1), .CNT_W(c_ws_w)) u_cnt_l (
      .clk(clk), .rst(reset), .i_clr(w_clr), .i_inc(w_m_carry),
      .o_count(w_l_cnt), .o_carry(w_l_carry)
   );

   conv_index_counter #(.MAX_VAL(INPUT_CHANNELS - 1), .CNT_W(c_k_w)) u_cnt_k (
      .clk(clk), .rst(reset), .i_clr(w_clr), .i_inc(w_l_carry),
      .o_count(w_k_cnt), .o_carry(w_k_carry)
   );

   conv_index_counter #(.MAX_VAL(NUM_NEURONS - 1), .CNT_W(c_n_w)) u_cnt_n (
      .clk(clk), .rst(reset), .i_clr(w_clr), .i_inc(w_handshake),
      .o_count(w_n_cnt), .o_carry(w_n_carry)
   );

   conv_index_counter #(.MAX_VAL(c_oh - 1), .CNT_W(c_j_w)) u_cnt_j (
      .clk(clk), .rst(reset), .i_clr(w_clr), .i_inc(w_n_carry),
      .o_count(w_j_cnt), .o_carry(w_j_carry)
   );

   conv_index_counter #(.MAX_VAL(c_ow - 1), .CNT_W(c_i_w)) u_cnt_i (
      .clk(clk), .rst(reset), .i_clr(w_clr), .i_inc(w_j_carry),
      .o_count(w_i_cnt), .o_carry(w_i_carry)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state. Abort is tested before the tap/handshake conditions
   // so it wins over out_ready.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (bus.abort)      w_next_state = ST_IDLE;
            else if (w_k_carry) w_next_state = ST_WAIT_OUT;
         end
         ST_WAIT_OUT: begin
            if (bus.abort)        w_next_state = ST_IDLE;
            else if (w_handshake) w_next_state = w_i_carry ? ST_DONE : ST_RUN;
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs, decoded from the state register and index counters only.
   // ------------------------------------------------------------------------
   always_comb begin
      bus.busy      = w_run || w_wait;
      bus.done      = (r_state == ST_DONE);
      bus.tap_valid = w_run;
      bus.tap_first = w_run && (w_k_cnt == '0) && (w_l_cnt == '0) && (w_m_cnt == '0);
      bus.tap_last  = w_run && (w_k_cnt == c_k_max) && (w_l_cnt == c_ws_max)
                      && (w_m_cnt == c_ws_max);
      bus.out_valid = w_wait;

      bus.in_addr  = '0;
      bus.w_addr   = '0;
      bus.out_addr = '0;

      if (w_run) begin
         bus.in_addr = c_in_aw'(((32'(w_i_cnt) + 32'(w_l_cnt)) * INPUT_HEIGHT
                                 + (32'(w_j_cnt) + 32'(w_m_cnt))) * INPUT_CHANNELS
                                 + 32'(w_k_cnt));
         bus.w_addr  = c_w_aw'(((32'(w_k_cnt) * WINDOW_SIZE + 32'(w_l_cnt)) * WINDOW_SIZE
                                + 32'(w_m_cnt)) * NUM_NEURONS + 32'(w_n_cnt));
      end

      if (w_wait) begin
         bus.out_addr = c_out_aw'((32'(w_i_cnt) * c_oh + 32'(w_j_cnt)) * NUM_NEURONS
                                  + 32'(w_n_cnt));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_sequencer
//  Purpose  : Directed self-checking bench for conv_sequencer on a 4x4
//             single-channel map, 3x3 window, two neurons (2x2 outputs,
//             9 taps per output, 8 outputs, 80 busy cycles per pass).
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_sequencer;

   localparam int TW  = 4;
   localparam int TH  = 4;
   localparam int TC  = 1;
   localparam int TWS = 3;
   localparam int TN  = 2;

   // First output: in_addr = l*4 + m, w_addr = (l*3 + m)*2.
   localparam logic [3:0] EXP_IN [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
   localparam logic [4:0] EXP_W  [9] = '{5'd0, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14, 5'd16};

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fails  = 0;

   conv_sequencer_if #(
      .INPUT_WIDTH(TW), .INPUT_HEIGHT(TH), .INPUT_CHANNELS(TC),
      .WINDOW_SIZE(TWS), .NUM_NEURONS(TN)
   ) bus ();

   conv_sequencer #(
      .INPUT_WIDTH(TW), .INPUT_HEIGHT(TH), .INPUT_CHANNELS(TC),
      .WINDOW_SIZE(TWS), .NUM_NEURONS(TN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fails);
      $fatal(1, "watchdog expired");
   end

   // Inputs change and outputs are sampled on the falling edge.
   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.busy      !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.done      !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_checks++; if (bus.tap_valid !== 1'b0) begin n_fails++; $display("FAIL reset_tap_valid: got %b expected 0", bus.tap_valid); end
      n_checks++; if (bus.tap_first !== 1'b0) begin n_fails++; $display("FAIL reset_tap_first: got %b expected 0", bus.tap_first); end
      n_checks++; if (bus.tap_last  !== 1'b0) begin n_fails++; $display("FAIL reset_tap_last: got %b expected 0", bus.tap_last); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_checks++; if (bus.in_addr   !== 4'd0) begin n_fails++; $display("FAIL reset_in_addr: got %0d expected 0", bus.in_addr); end
      n_checks++; if (bus.w_addr    !== 5'd0) begin n_fails++; $display("FAIL reset_w_addr: got %0d expected 0", bus.w_addr); end
      n_checks++; if (bus.out_addr  !== 3'd0) begin n_fails++; $display("FAIL reset_out_addr: got %0d expected 0", bus.out_addr); end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL idle_after_reset_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_full_pass();
      int         busy_cycles;
      int         done_cnt;
      int         out_cnt;
      int         cyc;
      logic [2:0] exp_out;
      busy_cycles = 0; done_cnt = 0; out_cnt = 0; cyc = 0; exp_out = 3'd0;
      bus.out_ready = 1'b1;
      pulse_start();
      while (!bus.done && cyc < 500) begin
         if (bus.busy) busy_cycles++;
         if (bus.out_valid) begin
            n_checks++;
            if (bus.out_addr !== exp_out) begin n_fails++; $display("FAIL full_out_addr: got %0d expected %0d", bus.out_addr, exp_out); end
            exp_out++; out_cnt++;
         end
         @(negedge clk); cyc++;
      end
      n_checks++; if (bus.done !== 1'b1) begin n_fails++; $display("FAIL full_done_timeout: done=%b after %0d cycles expected 1", bus.done, cyc); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL full_busy_at_done: got %b expected 0", bus.busy); end
      n_checks++; if (busy_cycles != 80) begin n_fails++; $display("FAIL full_busy_cycles: got %0d expected 80", busy_cycles); end
      n_checks++; if (out_cnt != 8) begin n_fails++; $display("FAIL full_out_count: got %0d expected 8", out_cnt); end
      repeat (5) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      n_checks++; if (done_cnt != 0) begin n_fails++; $display("FAIL full_extra_done: got %0d extra pulses expected 0", done_cnt); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL full_idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_first_taps();
      bus.out_ready = 1'b1;
      pulse_start();
      for (int t = 0; t < 9; t++) begin
         n_checks++; if (bus.tap_valid !== 1'b1) begin n_fails++; $display("FAIL taps_valid[%0d]: got %b expected 1", t, bus.tap_valid); end
         n_checks++; if (bus.in_addr !== EXP_IN[t]) begin n_fails++; $display("FAIL taps_in_addr[%0d]: got %0d expected %0d", t, bus.in_addr, EXP_IN[t]); end
         n_checks++; if (bus.w_addr !== EXP_W[t]) begin n_fails++; $display("FAIL taps_w_addr[%0d]: got %0d expected %0d", t, bus.w_addr, EXP_W[t]); end
         n_checks++; if (bus.tap_first !== (t == 0)) begin n_fails++; $display("FAIL taps_first[%0d]: got %b expected %b", t, bus.tap_first, (t == 0)); end
         n_checks++; if (bus.tap_last !== (t == 8)) begin n_fails++; $display("FAIL taps_last[%0d]: got %b expected %b", t, bus.tap_last, (t == 8)); end
         n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL taps_out_valid[%0d]: got %b expected 0", t, bus.out_valid); end
         @(negedge clk);
      end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL wait_out_valid: got %b expected 1", bus.out_valid); end
      n_checks++; if (bus.out_addr !== 3'd0) begin n_fails++; $display("FAIL wait_out_addr: got %0d expected 0", bus.out_addr); end
      n_checks++; if (bus.tap_valid !== 1'b0) begin n_fails++; $display("FAIL wait_tap_valid: got %b expected 0", bus.tap_valid); end
      n_checks++; if ({bus.in_addr, bus.w_addr} !== 9'd0) begin n_fails++; $display("FAIL wait_tap_addrs: got %0d/%0d expected 0/0", bus.in_addr, bus.w_addr); end
      @(negedge clk);
      // Second output: neuron 1, same window.
      n_checks++; if (bus.tap_first !== 1'b1) begin n_fails++; $display("FAIL n1_tap_first: got %b expected 1", bus.tap_first); end
      n_checks++; if (bus.w_addr !== 5'd1) begin n_fails++; $display("FAIL n1_w_addr: got %0d expected 1", bus.w_addr); end
      n_checks++; if (bus.in_addr !== 4'd0) begin n_fails++; $display("FAIL n1_in_addr: got %0d expected 0", bus.in_addr); end
      n_checks++; if (bus.out_addr !== 3'd0) begin n_fails++; $display("FAIL n1_out_addr_masked: got %0d expected 0", bus.out_addr); end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL taps_abort_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_backpressure();
      int         busy_cycles;
      int         cyc;
      busy_cycles = 0; cyc = 0;
      bus.out_ready = 1'b1;
      pulse_start();
      while (!bus.out_valid && cyc < 50) begin
         if (bus.busy) busy_cycles++;
         @(negedge clk); cyc++;
      end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_first_out_timeout: out_valid=%b expected 1", bus.out_valid); end
      busy_cycles++;
      bus.out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         if (bus.busy) busy_cycles++;
         n_checks++; if (bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", s, bus.out_valid); end
         n_checks++; if (bus.out_addr !== 3'd0) begin n_fails++; $display("FAIL bp_out_addr[%0d]: got %0d expected 0", s, bus.out_addr); end
         n_checks++; if (bus.tap_valid !== 1'b0) begin n_fails++; $display("FAIL bp_tap_valid[%0d]: got %b expected 0", s, bus.tap_valid); end
      end
      bus.out_ready = 1'b1;
      cyc = 0;
      while (!bus.done && cyc < 500) begin
         @(negedge clk); cyc++;
         if (bus.busy) busy_cycles++;
      end
      n_checks++; if (bus.done !== 1'b1) begin n_fails++; $display("FAIL bp_done_timeout: done=%b expected 1", bus.done); end
      n_checks++; if (busy_cycles != 85) begin n_fails++; $display("FAIL bp_busy_cycles: got %0d expected 85", busy_cycles); end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int done_seen;
      done_seen = 0;
      bus.out_ready = 1'b1;
      pulse_start();
      repeat (2) @(negedge clk);
      // Third RUN cycle: m = 2.
      n_checks++; if (bus.in_addr !== 4'd2) begin n_fails++; $display("FAIL abort_third_tap: got %0d expected 2", bus.in_addr); end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fails++; $display("FAIL abort_done: got %b expected 0", bus.done); end
      repeat (3) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      n_checks++; if (done_seen != 0) begin n_fails++; $display("FAIL abort_late_done: got %0d pulses expected 0", done_seen); end
      pulse_start();
      n_checks++; if (bus.in_addr !== 4'd0) begin n_fails++; $display("FAIL restart_in_addr: got %0d expected 0", bus.in_addr); end
      n_checks++; if (bus.tap_first !== 1'b1) begin n_fails++; $display("FAIL restart_tap_first: got %b expected 1", bus.tap_first); end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
   endtask

   task automatic test_start_while_busy();
      int         busy_cycles;
      int         out_cnt;
      int         cyc;
      logic [2:0] exp_out;
      busy_cycles = 0; out_cnt = 0; cyc = 0; exp_out = 3'd0;
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      while (!bus.done && cyc < 500) begin
         if (cyc == 20) bus.start = 1'b0;
         if (bus.busy) busy_cycles++;
         if (bus.out_valid) begin
            n_checks++;
            if (bus.out_addr !== exp_out) begin n_fails++; $display("FAIL swb_out_addr: got %0d expected %0d", bus.out_addr, exp_out); end
            exp_out++; out_cnt++;
         end
         @(negedge clk); cyc++;
      end
      bus.start = 1'b0;
      n_checks++; if (bus.done !== 1'b1) begin n_fails++; $display("FAIL swb_done_timeout: done=%b expected 1", bus.done); end
      n_checks++; if (busy_cycles != 80) begin n_fails++; $display("FAIL swb_busy_cycles: got %0d expected 80", busy_cycles); end
      n_checks++; if (out_cnt != 8) begin n_fails++; $display("FAIL swb_out_count: got %0d expected 8", out_cnt); end
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL swb_idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_reset_in_wait();
      int cyc;
      cyc = 0;
      bus.out_ready = 1'b1;
      pulse_start();
      // Run into the second output's wait so indices are non-zero.
      repeat (10) @(negedge clk);
      while (!bus.out_valid && cyc < 50) begin
         @(negedge clk); cyc++;
      end
      n_checks++; if (bus.out_addr !== 3'd1) begin n_fails++; $display("FAIL rst_wait_pre_addr: got %0d expected 1", bus.out_addr); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.tap_valid, bus.tap_first, bus.tap_last, bus.out_valid,
           bus.in_addr, bus.w_addr, bus.out_addr} !== 18'd0) begin
         n_fails++;
         $display("FAIL rst_wait_outputs: got busy=%b done=%b tv=%b tf=%b tl=%b ov=%b in=%0d w=%0d out=%0d expected all 0",
                  bus.busy, bus.done, bus.tap_valid, bus.tap_first, bus.tap_last, bus.out_valid,
                  bus.in_addr, bus.w_addr, bus.out_addr);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fails++; $display("FAIL rst_wait_idle: got %b expected 0", bus.busy); end
      pulse_start();
      n_checks++; if (bus.tap_first !== 1'b1) begin n_fails++; $display("FAIL rst_restart_first: got %b expected 1", bus.tap_first); end
      n_checks++; if ({bus.in_addr, bus.w_addr} !== 9'd0) begin n_fails++; $display("FAIL rst_restart_addrs: got %0d/%0d expected 0/0", bus.in_addr, bus.w_addr); end
      cyc = 0;
      while (!bus.out_valid && cyc < 50) begin
         @(negedge clk); cyc++;
      end
      n_checks++; if (bus.out_addr !== 3'd0 || bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL rst_restart_out: valid=%b addr=%0d expected 1/0", bus.out_valid, bus.out_addr); end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_full_pass();
      test_first_taps();
      test_backpressure();
      test_abort();
      test_start_while_busy();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
